// File: rtl/mem_bridge.sv
// Memory-stage bridge: splits M-stage loads/stores between zero-wait data memory
// and NDEV handshaked devices, and raises AdEL/AdES codes for CP0.
module mem_bridge #(
  parameter int          NDEV       = 2,
  parameter logic [31:0] DEV_BASE   = 32'h7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter int          DEV_WORDS  = 3,
  parameter logic [31:0] DM_TOP     = 32'h2fff,
  parameter int          TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 kill,
  input  logic [31:0]          dm_rdata,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [32*NDEV-1:0]   dev_rdata,
  output logic                 dm_we,
  output logic                 dev_req,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [29:0]          dev_addr,
  output logic [31:0]          dev_wdata,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic [4:0]           exc_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_reg;
  logic            dev_req_reg;
  logic [NDEV-1:0] dev_sel_reg;
  logic            dev_we_reg;
  logic [29:0]     dev_addr_reg;
  logic [31:0]     dev_wdata_reg;
  logic [31:0]     rbuf_reg;
  logic            err_reg;
  logic [CW-1:0]   wait_cnt_reg;

  logic            active;
  logic            dm_hit;
  logic            any_dev;
  logic            ro_hit;
  logic            misalign;
  logic            narrow_dev;
  logic            no_hit;
  logic            exc;
  logic            dev_start;
  logic            ack_hit;
  logic [NDEV-1:0] dev_hit;
  logic [NDEV-1:0] ro_hit_vec;
  logic [31:0]     sel_word [NDEV];
  logic [31:0]     ack_rdata;

  // Per-device window decode and one-hot read-data gating.
  genvar gi;
  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_dev
      localparam logic [31:0] WIN_LO = DEV_BASE + DEV_STRIDE * 32'(gi);
      localparam logic [31:0] WIN_HI = WIN_LO + 32'(4 * DEV_WORDS) - 32'd1;
      localparam logic [31:0] RO_LO  = WIN_LO + 32'(4 * (DEV_WORDS - 1));

      assign dev_hit[gi]    = (addr >= WIN_LO) && (addr <= WIN_HI);
      assign ro_hit_vec[gi] = (addr >= RO_LO)  && (addr <= WIN_HI);
      assign sel_word[gi]   = dev_sel_reg[gi] ? dev_rdata[32*gi +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    ack_rdata = 32'd0;
    for (int i = 0; i < NDEV; i++) begin
      ack_rdata = ack_rdata | sel_word[i];
    end
  end

  assign active     = req & (size != 2'd0);
  assign dm_hit     = (addr <= DM_TOP);
  assign any_dev    = |dev_hit;
  assign ro_hit     = |ro_hit_vec;
  assign misalign   = ((size == 2'd1) && (addr[1:0] != 2'b00)) ||
                      ((size == 2'd2) && addr[0]);
  assign narrow_dev = any_dev && ((size == 2'd2) || (size == 2'd3));
  assign no_hit     = ~dm_hit & ~any_dev;

  // Address exceptions are only decoded for a fresh access; a device access in
  // flight reports its outcome through err_reg in DONE instead.
  assign exc = active & (state_reg == IDLE) &
               (misalign | narrow_dev | no_hit | (we & ro_hit));

  // Reset gating keeps stall low while reset is held with a device address on the bus.
  assign dev_start = active & any_dev & ~exc & (state_reg == IDLE) & ~reset;
  assign ack_hit   = |(dev_ack & dev_sel_reg);

  assign dm_we = req & we & dm_hit & ~exc & ~kill;
  assign stall = (dev_start | (state_reg == WAIT)) & ~kill;
  assign rdata = (state_reg == DONE) ? rbuf_reg : dm_rdata;

  always_comb begin
    exc_code = 5'd0;
    if (exc) begin
      exc_code = we ? 5'd5 : 5'd4;
    end else if ((state_reg == DONE) && err_reg) begin
      exc_code = dev_we_reg ? 5'd5 : 5'd4;
    end
  end

  assign dev_req   = dev_req_reg;
  assign dev_sel   = dev_sel_reg;
  assign dev_we    = dev_we_reg;
  assign dev_addr  = dev_addr_reg;
  assign dev_wdata = dev_wdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      dev_req_reg   <= 1'b0;
      dev_sel_reg   <= '0;
      dev_we_reg    <= 1'b0;
      dev_addr_reg  <= 30'd0;
      dev_wdata_reg <= 32'd0;
      rbuf_reg      <= 32'd0;
      err_reg       <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dev_start && !kill) begin
            state_reg     <= WAIT;
            dev_req_reg   <= 1'b1;
            dev_sel_reg   <= dev_hit;
            dev_we_reg    <= we;
            dev_addr_reg  <= addr[31:2];
            dev_wdata_reg <= wdata;
            wait_cnt_reg  <= '0;
          end
        end
        WAIT: begin
          // Kill beats ack, and ack beats a timeout landing on the same cycle.
          if (kill) begin
            state_reg   <= IDLE;
            dev_req_reg <= 1'b0;
            dev_sel_reg <= '0;
          end else if (ack_hit) begin
            state_reg   <= DONE;
            rbuf_reg    <= ack_rdata;
            err_reg     <= 1'b0;
            dev_req_reg <= 1'b0;
            dev_sel_reg <= '0;
          end else begin
            if (wait_cnt_reg != CW'(TIMEOUT)) begin
              wait_cnt_reg <= wait_cnt_reg + CW'(1);
            end
            if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
              state_reg   <= DONE;
              err_reg     <= 1'b1;
              dev_req_reg <= 1'b0;
              dev_sel_reg <= '0;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          dev_req_reg <= 1'b0;
          dev_sel_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: DM path, device handshake, decode exceptions,
// timeout, kill and asynchronous reset, with hand-computed expectations.
module tb_mem_bridge;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        kill;
  logic [31:0] dm_rdata;
  logic [1:0]  dev_ack;
  logic [63:0] dev_rdata;
  logic        dm_we;
  logic        dev_req;
  logic [1:0]  dev_sel;
  logic        dev_we;
  logic [29:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic [4:0]  exc_code;

  int n_cmp = 0;
  int n_err = 0;

  mem_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .kill      (kill),
    .dm_rdata  (dm_rdata),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata),
    .dm_we     (dm_we),
    .dev_req   (dev_req),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .rdata     (rdata),
    .stall     (stall),
    .exc_code  (exc_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a);
    req  = 1'b1;
    we   = w;
    size = s;
    addr = a;
  endtask

  task automatic idle_bus();
    req     = 1'b0;
    we      = 1'b0;
    size    = 2'd0;
    addr    = 32'd0;
    kill    = 1'b0;
    dev_ack = 2'b00;
  endtask

  initial begin
    reset     = 1'b1;
    wdata     = 32'd0;
    dm_rdata  = 32'd0;
    dev_rdata = 64'd0;
    idle_bus();

    // Reset state
    cyc();
    chk("rst_dev_req",   32'(dev_req),   32'h0);
    chk("rst_dev_sel",   32'(dev_sel),   32'h0);
    chk("rst_dev_we",    32'(dev_we),    32'h0);
    chk("rst_dev_addr",  32'(dev_addr),  32'h0);
    chk("rst_dev_wdata", dev_wdata,      32'h0);
    chk("rst_stall",     32'(stall),     32'h0);
    chk("rst_exc",       32'(exc_code),  32'h0);
    reset = 1'b0;

    // DM word load and store, zero wait
    cyc();
    access(1'b0, 2'd1, 32'h0010);
    dm_rdata = 32'hdeadbeef;
    #1;
    chk("dm_ld_rdata", rdata,          32'hdeadbeef);
    chk("dm_ld_stall", 32'(stall),     32'h0);
    chk("dm_ld_exc",   32'(exc_code),  32'h0);
    chk("dm_ld_we",    32'(dm_we),     32'h0);
    access(1'b1, 2'd1, 32'h0020);
    #1;
    chk("dm_st_we",    32'(dm_we),     32'h1);
    chk("dm_st_stall", 32'(stall),     32'h0);
    kill = 1'b1;
    #1;
    chk("dm_st_kill_we", 32'(dm_we),   32'h0);
    kill = 1'b0;
    access(1'b0, 2'd1, 32'h2ffc);
    #1;
    chk("dm_top_exc",  32'(exc_code),  32'h0);
    access(1'b0, 2'd1, 32'h3000);
    #1;
    chk("dm_past_exc",   32'(exc_code), 32'h4);
    chk("dm_past_stall", 32'(stall),    32'h0);
    access(1'b1, 2'd1, 32'h7f0c);
    #1;
    chk("gap_st_exc",  32'(exc_code),  32'h5);
    cyc();
    idle_bus();
    #1;
    chk("dm_dev_req",  32'(dev_req),   32'h0);

    // Word store to device 1, ack in the 3rd WAIT cycle, stray ack from device 0
    access(1'b1, 2'd1, 32'h7f14);
    wdata = 32'hcafef00d;
    #1;
    chk("st_c0_stall",   32'(stall),   32'h1);
    chk("st_c0_req",     32'(dev_req), 32'h0);
    cyc();
    chk("st_w1_req",     32'(dev_req),  32'h1);
    chk("st_w1_sel",     32'(dev_sel),  32'h2);
    chk("st_w1_addr",    32'(dev_addr), 32'h1fc5);
    chk("st_w1_we",      32'(dev_we),   32'h1);
    chk("st_w1_wdata",   dev_wdata,     32'hcafef00d);
    chk("st_w1_stall",   32'(stall),    32'h1);
    dev_ack = 2'b01;
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("st_w2_stall",   32'(stall),   32'h1);
    chk("st_w2_req",     32'(dev_req), 32'h1);
    cyc();
    dev_ack = 2'b10;
    #1;
    chk("st_w3_stall",   32'(stall),   32'h1);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("st_done_stall", 32'(stall),    32'h0);
    chk("st_done_exc",   32'(exc_code), 32'h0);
    chk("st_done_req",   32'(dev_req),  32'h0);
    chk("st_done_sel",   32'(dev_sel),  32'h0);
    cyc();
    idle_bus();
    #1;
    chk("st_idle_stall", 32'(stall),   32'h0);
    chk("st_idle_req",   32'(dev_req), 32'h0);

    // Word load from device 1 with ack in the first WAIT cycle
    access(1'b0, 2'd1, 32'h7f10);
    dev_rdata = {32'h12345678, 32'haaaaaaaa};
    #1;
    chk("ld_c0_stall",   32'(stall),   32'h1);
    cyc();
    dev_ack = 2'b10;
    #1;
    chk("ld_w1_stall",   32'(stall),   32'h1);
    chk("ld_w1_sel",     32'(dev_sel), 32'h2);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("ld_done_rdata", rdata,          32'h12345678);
    chk("ld_done_exc",   32'(exc_code),  32'h0);
    chk("ld_done_stall", 32'(stall),     32'h0);
    cyc();
    idle_bus();

    // Decode exceptions
    access(1'b0, 2'd2, 32'h0003);
    #1;
    chk("half_mis_exc",   32'(exc_code), 32'h4);
    chk("half_mis_stall", 32'(stall),    32'h0);
    access(1'b1, 2'd3, 32'h7f00);
    #1;
    chk("byte_dev_exc",   32'(exc_code), 32'h5);
    chk("byte_dev_stall", 32'(stall),    32'h0);
    chk("byte_dev_dmwe",  32'(dm_we),    32'h0);
    cyc();
    chk("byte_dev_req",   32'(dev_req),  32'h0);
    access(1'b1, 2'd1, 32'h7f08);
    #1;
    chk("ro_st_exc",      32'(exc_code), 32'h5);
    chk("ro_st_stall",    32'(stall),    32'h0);
    access(1'b0, 2'd2, 32'h7f02);
    #1;
    chk("half_dev_exc",   32'(exc_code), 32'h4);
    access(1'b0, 2'd1, 32'h7f05);
    #1;
    chk("word_mis_exc",   32'(exc_code), 32'h4);
    cyc();
    chk("exc_no_req",     32'(dev_req),  32'h0);
    idle_bus();

    // Timeout: 15 WAIT cycles with no ack, late ack in DONE ignored
    access(1'b0, 2'd1, 32'h7f04);
    #1;
    chk("to_c0_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("to_w%0d_stall", i + 1), 32'(stall),   32'h1);
      chk($sformatf("to_w%0d_req", i + 1),   32'(dev_req), 32'h1);
    end
    chk("to_addr",       32'(dev_addr),  32'h1fc1);
    chk("to_sel",        32'(dev_sel),   32'h1);
    cyc();
    dev_ack = 2'b01;
    #1;
    chk("to_done_stall", 32'(stall),     32'h0);
    chk("to_done_exc",   32'(exc_code),  32'h4);
    chk("to_done_req",   32'(dev_req),   32'h0);
    cyc();
    idle_bus();
    #1;
    chk("to_idle_exc",   32'(exc_code),  32'h0);
    chk("to_idle_stall", 32'(stall),     32'h0);
    chk("to_idle_req",   32'(dev_req),   32'h0);

    // Ack coinciding with the last allowed WAIT cycle wins over the timeout
    access(1'b0, 2'd1, 32'h7f10);
    dev_rdata = {32'h0badf00d, 32'h11111111};
    cyc();
    for (int i = 0; i < 14; i++) begin
      cyc();
    end
    dev_ack = 2'b10;
    #1;
    chk("race_w15_stall", 32'(stall), 32'h1);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("race_done_exc",   32'(exc_code), 32'h0);
    chk("race_done_rdata", rdata,         32'h0badf00d);
    cyc();
    idle_bus();

    // Kill in the 2nd WAIT cycle, ack arrives afterwards
    access(1'b0, 2'd1, 32'h7f04);
    #1;
    chk("kill_c0_stall", 32'(stall),   32'h1);
    cyc();
    chk("kill_w1_req",   32'(dev_req), 32'h1);
    cyc();
    kill = 1'b1;
    #1;
    chk("kill_w2_stall", 32'(stall),   32'h0);
    cyc();
    idle_bus();
    dev_ack  = 2'b01;
    dm_rdata = 32'h5555aaaa;
    #1;
    chk("kill_req",   32'(dev_req),  32'h0);
    chk("kill_sel",   32'(dev_sel),  32'h0);
    chk("kill_stall", 32'(stall),    32'h0);
    chk("kill_exc",   32'(exc_code), 32'h0);
    chk("kill_rdata", rdata,         32'h5555aaaa);
    cyc();
    dev_ack = 2'b00;
    #1;
    chk("kill_after_req",   32'(dev_req),  32'h0);
    chk("kill_after_rdata", rdata,         32'h5555aaaa);

    // Asynchronous reset mid-WAIT, then a DM load
    access(1'b0, 2'd1, 32'h7f04);
    #1;
    chk("ar_c0_stall", 32'(stall),   32'h1);
    cyc();
    chk("ar_w1_req",   32'(dev_req), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req",   32'(dev_req), 32'h0);
    chk("ar_sel",   32'(dev_sel), 32'h0);
    chk("ar_stall", 32'(stall),   32'h0);
    cyc();
    reset = 1'b0;
    idle_bus();
    cyc();
    access(1'b0, 2'd1, 32'h0040);
    dm_rdata = 32'h13579bdf;
    #1;
    chk("ar_dm_rdata", rdata,          32'h13579bdf);
    chk("ar_dm_stall", 32'(stall),     32'h0);
    chk("ar_dm_exc",   32'(exc_code),  32'h0);
    cyc();
    chk("ar_dm_req",   32'(dev_req),   32'h0);
    idle_bus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
